// File: rtl/farrow_resample_ctrl.sv
// farrow_resample_ctrl
//   Rate controller in front of the Farrow FIR branch bank. An NCO phase
//   accumulator produces one fractional interval (mu) per output sample and
//   decides, on each output, whether the tap chain advances by one input.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   step    [FRAC:0]    phase increment per output (Q1.FRAC, 1..2^FRAC)
//   s_data  [BITS-1:0]  input sample            (s_valid / s_ready)
//   x_out   [BITS-1:0]  sample for the tap chain, qualified by x_adv strobe
//   mu      [FRAC-1:0]  fractional interval     (m_valid / m_ready)
module farrow_resample_ctrl #(
  parameter int unsigned BITS = 16,
  parameter int unsigned FRAC = 16,
  parameter int unsigned N    = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [FRAC:0]   step,
  input  logic [BITS-1:0] s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [BITS-1:0] x_out,
  output logic            x_adv,
  output logic [FRAC-1:0] mu,
  output logic            m_valid,
  input  logic            m_ready
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [FRAC:0] STEP_MAX = {1'b1, {FRAC{1'b0}}};

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_FETCH = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [FRAC-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic [BITS-1:0] r_x;
  logic            r_adv;

  logic [FRAC:0]   w_step_e;
  logic [FRAC:0]   w_sum;
  logic            w_carry;
  logic            w_s_ready;
  logic            w_m_valid;
  logic            w_in_hs;
  logic            w_out_hs;
  logic            w_last_prime;

  // Illegal increments (0 or above one full cycle) saturate to one full cycle
  assign w_step_e = ((step == '0) || (step > STEP_MAX)) ? STEP_MAX : step;
  assign w_sum    = {1'b0, r_acc} + w_step_e;
  assign w_carry  = w_sum[FRAC];

  assign w_in_hs      = s_valid && w_s_ready;
  assign w_out_hs     = w_m_valid && m_ready;
  assign w_last_prime = (r_cnt == CW'(N - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PRIME: if (w_in_hs && w_last_prime) w_state_nxt = ST_RUN;
      // A carry with no sample waiting parks the NCO until one arrives
      ST_RUN:   if (w_out_hs && w_carry && !s_valid) w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_in_hs) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_PRIME;
    endcase
  end

  // Output decode; in RUN an input is only taken together with a carrying output
  always_comb begin
    w_s_ready = 1'b0;
    w_m_valid = 1'b0;
    case (r_state)
      ST_PRIME: w_s_ready = 1'b1;
      ST_RUN: begin
        w_m_valid = 1'b1;
        w_s_ready = m_ready && w_carry;
      end
      ST_FETCH: w_s_ready = 1'b1;
      default: begin
        w_s_ready = 1'b0;
        w_m_valid = 1'b0;
      end
    endcase
  end

  // Prime counter, phase accumulator and tap-chain shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_x   <= '0;
      r_adv <= 1'b0;
    end else begin
      if ((r_state == ST_PRIME) && w_in_hs) begin
        r_cnt <= w_last_prime ? '0 : r_cnt + CW'(1);
      end
      if (w_out_hs) begin
        r_acc <= w_sum[FRAC-1:0];
      end
      r_adv <= w_in_hs;
      if (w_in_hs) begin
        r_x <= s_data;
      end
    end
  end

  assign s_ready = w_s_ready;
  assign m_valid = w_m_valid;
  assign mu      = r_acc;
  assign x_out   = r_x;
  assign x_adv   = r_adv;

endmodule
